// File: rtl/completion_writeback_queue_if.sv
// Completion writeback queue bus: execute-side result lanes
// plus the ROB-side drain slots and flow-control status.
interface completion_writeback_queue_if #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 96
);
  logic [2:0]             in_valid;
  logic [3*PAYLOAD_W-1:0] in_payload;
  logic                   wb_allowin;
  logic                   drain_en;
  logic [1:0]             out_valid;
  logic [2*PAYLOAD_W-1:0] out_payload;
  logic [$clog2(DEPTH):0] occupancy;

  // Environment side: drives lanes and drain enable.
  modport master (
    output in_valid,
    output in_payload,
    output drain_en,
    input  wb_allowin,
    input  out_valid,
    input  out_payload,
    input  occupancy
  );

  // Queue side.
  modport slave (
    input  in_valid,
    input  in_payload,
    input  drain_en,
    output wb_allowin,
    output out_valid,
    output out_payload,
    output occupancy
  );
endinterface

// File: rtl/completion_writeback_queue.sv
// Completion writeback queue: compacts up to three execute
// results per cycle into a FIFO and drains two per cycle.
module completion_writeback_queue #(
  parameter int DEPTH          = 8,
  parameter int PAYLOAD_W      = 96,
  parameter int ALLOWIN_MARGIN = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  completion_writeback_queue_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] MARGIN_C = PW'(ALLOWIN_MARGIN);
  localparam logic [PW-1:0] ONE_C    = PW'(1);
  localparam logic [PW-1:0] TWO_C    = PW'(2);

  logic [PW-1:0]        head_q;
  logic [PW-1:0]        head_d;
  logic [PW-1:0]        tail_q;
  logic [PW-1:0]        tail_d;
  logic                 allowin_q;
  logic                 allowin_d;
  logic [PAYLOAD_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] occ;
  logic [PW-1:0] free;
  logic [PW-1:0] enq_n;
  logic [PW-1:0] deq_n;
  logic [PW-1:0] occ_nxt;
  logic [2:0]    wen;
  logic [AW-1:0] waddr [3];
  logic [AW-1:0] raddr0;
  logic [AW-1:0] raddr1;

  // Occupancy and free space from the wrap-bit pointers.
  always_comb begin
    occ  = tail_q - head_q;
    free = DEPTH_C - occ;
  end

  // Compact valid lanes onto consecutive slots; lanes that
  // do not fit are dropped so head is never overrun.
  always_comb begin
    enq_n = '0;
    wen   = '0;
    for (int i = 0; i < 3; i++) begin
      waddr[i] = tail_q[AW-1:0] + enq_n[AW-1:0];
      if (wb.in_valid[i] && (enq_n < free)) begin
        wen[i] = 1'b1;
        enq_n  = enq_n + ONE_C;
      end
    end
  end

  // Drain count: up to two oldest entries when the ROB accepts.
  always_comb begin
    deq_n = '0;
    if (wb.drain_en) begin
      if (occ >= TWO_C) begin
        deq_n = TWO_C;
      end else if (occ == ONE_C) begin
        deq_n = ONE_C;
      end
    end
  end

  // Next pointers and registered issue back-pressure.
  always_comb begin
    head_d    = head_q + deq_n;
    tail_d    = tail_q + enq_n;
    occ_nxt   = occ + enq_n - deq_n;
    allowin_d = (DEPTH_C - occ_nxt) >= MARGIN_C;
  end

  // Pointer and allowin state; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head_q    <= '0;
      tail_q    <= '0;
      allowin_q <= 1'b1;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      allowin_q <= allowin_d;
    end
  end

  // Payload storage is not reset; only accepted lanes write.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      for (int i = 0; i < 3; i++) begin
        if (wen[i]) begin
          mem_q[waddr[i]] <=
            wb.in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  // Read the two oldest entries straight from storage.
  always_comb begin
    raddr0         = head_q[AW-1:0];
    raddr1         = head_q[AW-1:0] + 1'b1;
    wb.out_valid   = {occ >= TWO_C, occ != '0};
    wb.out_payload = {mem_q[raddr1], mem_q[raddr0]};
    wb.occupancy   = occ;
    wb.wb_allowin  = allowin_q;
  end

  // Upstream must never present more results than free slots.
  property p_no_overflow;
    @(posedge clk) disable iff (!resetn || flush)
      PW'($countones(wb.in_valid)) <= free;
  endproperty
  a_no_overflow: assert property (p_no_overflow);

endmodule
